pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Parametrised hazard and control unit for the five-stage Y86 pipeline: generates per-stage stall/bubble controls from decode/execute/memory/writeback state. Beyond load/use, ret and mispredict handling it adds a multi-cycle data-memory wait state machine, a sticky halted state on writeback exceptions, RNONE-aware operand matching and saturating hazard performance counters. Sits beside the pipeline registers; every stage register consumes its stall/bubble pair.

## Interface
- REG_W, 4: register-ID width; all-ones value is RNONE (no register).
- MEM_LAT, 1: data-memory access latency in cycles, 1..16; 1 = single-cycle memory, no waits.
- CNT_W, 16: width of each performance counter.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- D_icode, E_icode, M_icode  in  4 each  icodes in D, E, M registers.
- d_srcA, d_srcB  in  REG_W each  decode source IDs.
- E_dstM  in  REG_W  E-stage memory destination.
- e_Cnd  in  1  execute branch condition.
- m_stat, W_stat  in  4 each  status (1 AOK, 2 HLT, 3 ADR, 4 INS).
- F_stall, D_stall, E_stall, M_stall, W_stall  out  1 each.
- D_bubble, E_bubble, M_bubble, W_bubble  out  1 each.
- halted  out  1  sticky halted flag.
- perf_loaduse, perf_ret, perf_mispred, perf_memwait  out  CNT_W each  saturating event counters.

## Operation
- Terms: exc(s) = s in {2,3,4}. lu = E_icode in {5,B} and E_dstM != RNONE and (E_dstM == d_srcA or E_dstM == d_srcB). ret = 9 in {D_icode, E_icode, M_icode}. mp = E_icode == 7 and !e_Cnd. memop = M_icode in {4,5,8,9,A,B} and !exc(m_stat).
- States RUN, WAIT, HALT; 5-bit down-counter wcnt.
- RUN → HALT when exc(W_stat). Else RUN → WAIT when memop and MEM_LAT > 1; wcnt ← MEM_LAT-2.
- WAIT: wcnt > 0 → wcnt decrements, stay; wcnt == 0 → RUN (release cycle). exc(W_stat) in WAIT → HALT.
- HALT: left only by rst.
- mw (memory wait active) = (RUN and memop and MEM_LAT > 1) or (WAIT and wcnt != 0). M instruction occupies M for exactly MEM_LAT cycles.
- Output priority, highest first:
  - HALT: all five stalls 1, all bubbles 0, halted 1.
  - exc(m_stat) or exc(W_stat): M_bubble 1; W_stall = exc(W_stat); F/D/E rules below still apply; no memory wait starts.
  - mw: F/D/E/M stalls 1, W_bubble 1, D_bubble = E_bubble = 0 (frozen E: mp and lu ignored).
  - normal: F_stall = lu or ret; D_stall = lu; D_bubble = mp or (ret and !lu); E_bubble = mp or lu; other stalls/bubbles 0.
- Counters (saturate at 2^CNT_W-1, never wrap), +1 on rising clk when effective: perf_loaduse on D_stall from lu; perf_ret on D_bubble from ret; perf_mispred on E_bubble from mp; perf_memwait on mw. No counting in HALT or during rst.

## Timing
- Stall/bubble outputs combinational from state and inputs, same cycle.
- State, wcnt, counters, halted registered; updated on rising clk.
- While rst = 1: all stalls 0, D/E/M/W_bubble = 1 (pipeline flush), halted 0. At the edge with rst = 1: state RUN, wcnt 0, counters 0.
- rst mid-WAIT or in HALT: aborts wait/halt, RUN on next cycle.
- WAIT entry cycle already stalls (mw true in RUN); release cycle has all stalls 0, so the M instruction advances.
- Back-to-back memops: the next memop in M re-enters WAIT the cycle after release; no skipped wait.
- lu and mp together in normal mode: D_stall 1, D_bubble 1 (mp wins), E_bubble 1, F_stall 1.

## Test plan
- MEM_LAT=3, M_icode=5 (AOK) for one release: F/D/E/M_stall and W_bubble high for 2 cycles, low on 3rd; perf_memwait +2.
- E_icode=5, E_dstM=3, d_srcA=3, no other hazard: F_stall=D_stall=E_bubble=1, D_bubble=0; perf_loaduse +1. Repeat with E_dstM=F, d_srcB=F: no stall.
- E_icode=7, e_Cnd=0: D_bubble=E_bubble=1, stalls 0; perf_mispred +1. Same during a memory wait: no bubbles, counter unchanged.
- D_icode=9 for 3 cycles: F_stall=1, D_bubble=1 each cycle; perf_ret +3.
- W_stat=3: W_stall=1, M_bubble=1 same cycle; next cycle halted=1, all stalls 1 regardless of inputs; rst pulse → halted 0, counters 0.
- CNT_W=2, hold lu 5 cycles: perf_loaduse reaches 3 and stays 3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline state in, stall/bubble controls out for the hazard unit
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 4
);
  logic [3:0]       D_icode;
  logic [3:0]       E_icode;
  logic [3:0]       M_icode;
  logic [REG_W-1:0] d_srcA;
  logic [REG_W-1:0] d_srcB;
  logic [REG_W-1:0] E_dstM;
  logic             e_Cnd;
  logic [3:0]       m_stat;
  logic [3:0]       W_stat;

  logic             F_stall;
  logic             D_stall;
  logic             E_stall;
  logic             M_stall;
  logic             W_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_bubble;

  // Pipeline side: presents stage state, consumes controls
  modport master (
    output D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, e_Cnd, m_stat, W_stat,
    input  F_stall, D_stall, E_stall, M_stall, W_stall,
    input  D_bubble, E_bubble, M_bubble, W_bubble
  );

  // Hazard unit side
  modport slave (
    input  D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, e_Cnd, m_stat, W_stat,
    output F_stall, D_stall, E_stall, M_stall, W_stall,
    output D_bubble, E_bubble, M_bubble, W_bubble
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - Y86 five-stage hazard/control unit with memory wait FSM and perf counters
module pipeline_hazard_ctrl #(
  parameter int REG_W   = 4,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_hazard_ctrl_if.slave hz,
  output logic             halted,
  output logic [CNT_W-1:0] perf_loaduse,
  output logic [CNT_W-1:0] perf_ret,
  output logic [CNT_W-1:0] perf_mispred,
  output logic [CNT_W-1:0] perf_memwait
);

  localparam logic [REG_W-1:0] RNONE     = '1;
  localparam bit               LONG_MEM  = (MEM_LAT > 1);
  localparam logic [4:0]       WCNT_INIT = (MEM_LAT > 1) ? 5'(MEM_LAT - 2) : 5'd0;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [4:0]       r_wcnt;
  logic [4:0]       w_wcnt_nxt;
  logic [CNT_W-1:0] r_cnt_lu;
  logic [CNT_W-1:0] r_cnt_ret;
  logic [CNT_W-1:0] r_cnt_mp;
  logic [CNT_W-1:0] r_cnt_mw;

  logic w_lu;
  logic w_ret;
  logic w_mp;
  logic w_exc_m;
  logic w_exc_w;
  logic w_exc_any;
  logic w_memop;
  logic w_mw;
  logic w_mw_eff;
  logic w_active;
  logic w_ev_lu;
  logic w_ev_ret;
  logic w_ev_mp;
  logic w_ev_mw;

  logic w_f_stall;
  logic w_d_stall;
  logic w_e_stall;
  logic w_m_stall;
  logic w_w_stall;
  logic w_d_bubble;
  logic w_e_bubble;
  logic w_m_bubble;
  logic w_w_bubble;

  function automatic logic is_exc(input logic [3:0] s);
    return (s == 4'd2) || (s == 4'd3) || (s == 4'd4);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Hazard terms; RNONE in E_dstM never matches so absent operands cannot cause load/use
  always_comb begin
    w_lu      = (hz.E_icode inside {4'h5, 4'hB}) && (hz.E_dstM != RNONE) &&
                ((hz.E_dstM == hz.d_srcA) || (hz.E_dstM == hz.d_srcB));
    w_ret     = (hz.D_icode == 4'h9) || (hz.E_icode == 4'h9) || (hz.M_icode == 4'h9);
    w_mp      = (hz.E_icode == 4'h7) && !hz.e_Cnd;
    w_exc_m   = is_exc(hz.m_stat);
    w_exc_w   = is_exc(hz.W_stat);
    w_exc_any = w_exc_m || w_exc_w;
    w_memop   = (hz.M_icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) && !w_exc_m;
    w_mw      = ((r_state == ST_RUN) && w_memop && LONG_MEM) ||
                ((r_state == ST_WAIT) && (r_wcnt != 5'd0));
    // An excepting instruction outranks the wait, so the freeze only applies without one
    w_mw_eff  = w_mw && !w_exc_any;
    w_active  = !rst && (r_state != ST_HALT);
  end

  // Next-state logic for the RUN/WAIT/HALT machine and the wait down-counter
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      ST_RUN: begin
        if (w_exc_w) begin
          w_state_nxt = ST_HALT;
        end else if (w_memop && LONG_MEM) begin
          w_state_nxt = ST_WAIT;
          w_wcnt_nxt  = WCNT_INIT;
        end
      end
      ST_WAIT: begin
        if (w_exc_w) begin
          w_state_nxt = ST_HALT;
        end else if (r_wcnt != 5'd0) begin
          w_wcnt_nxt = r_wcnt - 5'd1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_wcnt_nxt  = 5'd0;
      end
    endcase
  end

  // State register; reset also aborts any wait or halt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_wcnt  <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Stall/bubble generation in priority order: reset flush, halt, exception, memory wait, normal
  always_comb begin
    w_f_stall  = 1'b0;
    w_d_stall  = 1'b0;
    w_e_stall  = 1'b0;
    w_m_stall  = 1'b0;
    w_w_stall  = 1'b0;
    w_d_bubble = 1'b0;
    w_e_bubble = 1'b0;
    w_m_bubble = 1'b0;
    w_w_bubble = 1'b0;
    if (rst) begin
      w_d_bubble = 1'b1;
      w_e_bubble = 1'b1;
      w_m_bubble = 1'b1;
      w_w_bubble = 1'b1;
    end else if (r_state == ST_HALT) begin
      w_f_stall = 1'b1;
      w_d_stall = 1'b1;
      w_e_stall = 1'b1;
      w_m_stall = 1'b1;
      w_w_stall = 1'b1;
    end else if (w_mw_eff) begin
      // E is frozen, so a mispredict or load/use seen there is acted on after the wait
      w_f_stall  = 1'b1;
      w_d_stall  = 1'b1;
      w_e_stall  = 1'b1;
      w_m_stall  = 1'b1;
      w_w_bubble = 1'b1;
    end else begin
      w_f_stall  = w_lu || w_ret;
      w_d_stall  = w_lu;
      w_d_bubble = w_mp || (w_ret && !w_lu);
      w_e_bubble = w_mp || w_lu;
      if (w_exc_any) begin
        w_m_bubble = 1'b1;
        w_w_stall  = w_exc_w;
      end
    end
  end

  // Counter events mirror the control that was actually asserted for each cause
  always_comb begin
    w_ev_lu  = w_active && !w_mw_eff && w_lu;
    w_ev_ret = w_active && !w_mw_eff && w_ret && !w_lu;
    w_ev_mp  = w_active && !w_mw_eff && w_mp;
    w_ev_mw  = w_active && w_mw_eff;
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_lu  <= '0;
      r_cnt_ret <= '0;
      r_cnt_mp  <= '0;
      r_cnt_mw  <= '0;
    end else begin
      r_cnt_lu  <= sat_inc(r_cnt_lu, w_ev_lu);
      r_cnt_ret <= sat_inc(r_cnt_ret, w_ev_ret);
      r_cnt_mp  <= sat_inc(r_cnt_mp, w_ev_mp);
      r_cnt_mw  <= sat_inc(r_cnt_mw, w_ev_mw);
    end
  end

  assign hz.F_stall  = w_f_stall;
  assign hz.D_stall  = w_d_stall;
  assign hz.E_stall  = w_e_stall;
  assign hz.M_stall  = w_m_stall;
  assign hz.W_stall  = w_w_stall;
  assign hz.D_bubble = w_d_bubble;
  assign hz.E_bubble = w_e_bubble;
  assign hz.M_bubble = w_m_bubble;
  assign hz.W_bubble = w_w_bubble;

  assign halted       = (r_state == ST_HALT) && !rst;
  assign perf_loaduse = r_cnt_lu;
  assign perf_ret     = r_cnt_ret;
  assign perf_mispred = r_cnt_mp;
  assign perf_memwait = r_cnt_mw;

endmodule
